// File: rtl/ac97_reg_sequencer_if.sv
// Signal bundle for the AC97 register sequencer: host command push,
// response strobe, controller register port and status/control lines.
interface ac97_reg_sequencer_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic              CMD_VALID;
  logic              CMD_READY;
  logic              CMD_RW;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [DATA_W-1:0] CMD_DATA;
  logic              RESP_VALID;
  logic              RESP_RW;
  logic [ADDR_W-1:0] RESP_ADDR;
  logic [DATA_W-1:0] RESP_DATA;
  logic              RESP_ERR;
  logic              CTRL_WE;
  logic              CTRL_RE;
  logic [ADDR_W-1:0] CTRL_REGID;
  logic [DATA_W-1:0] CTRL_DIN;
  logic              CTRL_RDY;
  logic [DATA_W-1:0] CTRL_DOUT;
  logic              CTRL_DOUT_VALID;
  logic [LVL_W-1:0]  LEVEL;
  logic              BUSY;
  logic              ERR_STICKY;
  logic              CLR_ERR;

  // Sequencer side
  modport slave (
    input  CMD_VALID, CMD_RW, CMD_ADDR, CMD_DATA,
    input  CTRL_RDY, CTRL_DOUT, CTRL_DOUT_VALID, CLR_ERR,
    output CMD_READY, RESP_VALID, RESP_RW, RESP_ADDR, RESP_DATA, RESP_ERR,
    output CTRL_WE, CTRL_RE, CTRL_REGID, CTRL_DIN, LEVEL, BUSY, ERR_STICKY
  );

  // Host / controller side
  modport master (
    output CMD_VALID, CMD_RW, CMD_ADDR, CMD_DATA,
    output CTRL_RDY, CTRL_DOUT, CTRL_DOUT_VALID, CLR_ERR,
    input  CMD_READY, RESP_VALID, RESP_RW, RESP_ADDR, RESP_DATA, RESP_ERR,
    input  CTRL_WE, CTRL_RE, CTRL_REGID, CTRL_DIN, LEVEL, BUSY, ERR_STICKY
  );
endinterface

// File: rtl/ac97_reg_sequencer.sv
// Queued AC97 register command sequencer. Commands are buffered in a FIFO,
// issued one at a time to the codec controller register port, bounded by a
// timeout, and answered with exactly one response each, in order.
module ac97_reg_sequencer #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                CLOCK,
  input  logic                RESET_N,
  ac97_reg_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int TC_W  = $clog2(TIMEOUT + 1);
  localparam int ENT_W = 1 + ADDR_W + DATA_W;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESPOND} state_t;

  state_t            state, state_n;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level, level_n;
  logic              full;
  logic              push, pop;
  logic              head_rw;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              hold_rw;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic [TC_W-1:0]   tcnt;
  logic              resp_load, resp_err_n;
  logic [DATA_W-1:0] resp_data_n;
  logic              resp_rw, resp_err, err_sticky;
  logic [ADDR_W-1:0] resp_addr;
  logic [DATA_W-1:0] resp_data;

  assign {head_rw, head_addr, head_data} = mem[rd_ptr];
  assign push    = bus.CMD_VALID && !full;
  assign level_n = level + LVL_W'(push) - LVL_W'(pop);

  // Command storage; contents need no reset since level gates every read
  always_ff @(posedge CLOCK) begin
    if (push) mem[wr_ptr] <= {bus.CMD_RW, bus.CMD_ADDR, bus.CMD_DATA};
  end

  // FIFO pointers, occupancy and registered full flag
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_n;
      full  <= (level_n == FULL_LVL);
    end
  end

  // Sequencer state register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_n;
  end

  // Next state, FIFO pop and response selection
  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    resp_load   = 1'b0;
    resp_err_n  = 1'b0;
    resp_data_n = '0;
    case (state)
      IDLE: begin
        if (level != '0 && bus.CTRL_RDY) begin
          pop = 1'b1;
          if (head_addr[0]) begin
            // Odd register addresses are rejected without touching the codec
            state_n    = RESPOND;
            resp_load  = 1'b1;
            resp_err_n = 1'b1;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      ISSUE: state_n = WAIT_ACK;
      WAIT_ACK: begin
        if (!bus.CTRL_RDY) begin
          state_n = WAIT_DONE;
        end else if (tcnt >= TC_LAST) begin
          state_n    = RESPOND;
          resp_load  = 1'b1;
          resp_err_n = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (hold_rw && bus.CTRL_DOUT_VALID) begin
          state_n     = RESPOND;
          resp_load   = 1'b1;
          resp_data_n = bus.CTRL_DOUT;
        end else if (!hold_rw && bus.CTRL_RDY) begin
          state_n   = RESPOND;
          resp_load = 1'b1;
        end else if (tcnt >= TC_LAST) begin
          state_n    = RESPOND;
          resp_load  = 1'b1;
          resp_err_n = 1'b1;
        end
      end
      RESPOND: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Holding register for the command in flight; drives REGID/DIN until done
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      hold_rw   <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else if (pop) begin
      hold_rw   <= head_rw;
      hold_addr <= head_addr;
      hold_data <= head_data;
    end
  end

  // Transaction timeout counter, spanning both wait states
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)                                  tcnt <= '0;
    else if (state == ISSUE)                       tcnt <= '0;
    else if (state == WAIT_ACK || state == WAIT_DONE) tcnt <= tcnt + TC_W'(1);
  end

  // Response fields, held until the next response is produced
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      resp_rw   <= 1'b0;
      resp_addr <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else if (resp_load) begin
      resp_rw   <= (state == IDLE) ? head_rw   : hold_rw;
      resp_addr <= (state == IDLE) ? head_addr : hold_addr;
      resp_data <= resp_data_n;
      resp_err  <= resp_err_n;
    end
  end

  // Sticky error flag; a new error wins over a simultaneous clear
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)                   err_sticky <= 1'b0;
    else if (resp_load && resp_err_n) err_sticky <= 1'b1;
    else if (bus.CLR_ERR)           err_sticky <= 1'b0;
  end

  assign bus.CMD_READY  = !full;
  assign bus.LEVEL      = level;
  assign bus.BUSY       = (state != IDLE) || (level != '0);
  assign bus.CTRL_WE    = (state == ISSUE) && !hold_rw;
  assign bus.CTRL_RE    = (state == ISSUE) && hold_rw;
  assign bus.CTRL_REGID = hold_addr;
  assign bus.CTRL_DIN   = hold_data;
  assign bus.RESP_VALID = (state == RESPOND);
  assign bus.RESP_RW    = resp_rw;
  assign bus.RESP_ADDR  = resp_addr;
  assign bus.RESP_DATA  = resp_data;
  assign bus.RESP_ERR   = resp_err;
  assign bus.ERR_STICKY = err_sticky;
endmodule

// File: tb/tb_ac97_reg_sequencer.sv
// Bench for ac97_reg_sequencer: a behavioural codec controller, a response
// monitor and an in-order reference model of expected responses.
module tb_ac97_reg_sequencer;
  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 32;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
  } resp_t;

  logic CLOCK = 1'b0;
  logic RESET_N;
  always #5 CLOCK = ~CLOCK;

  ac97_reg_sequencer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ac97_reg_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK  (CLOCK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  resp_t got_q[$];
  resp_t exp_q[$];
  logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
  bit ctl_hold = 1'b0;
  bit ctl_hang = 1'b0;
  bit ctl_rand = 1'b0;
  int ack_dly  = 1;
  int busy_dly = 1;
  int cyc = 0, n_we = 0, n_re = 0, n_badstb = 0, iss_cyc = 0, resp_cyc = 0;

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return (i == 'h1A) ? 16'h0404 : 16'(i * 'h0313 + 'h1F00);
  endfunction

  // Expected response of one accepted command, evaluated in queue order
  function automatic resp_t ref_resp(input logic rw, input logic [ADDR_W-1:0] a,
                                     input logic [DATA_W-1:0] d, input bit hang);
    resp_t r;
    r.rw = rw; r.addr = a; r.data = '0; r.err = 1'b0;
    if (a[0] || hang) r.err = 1'b1;
    else if (rw)      r.data = ref_mem[a];
    else              ref_mem[a] = d;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input bit hang, output bit acc);
    @(posedge CLOCK); #1;
    bus.CMD_VALID = 1'b1; bus.CMD_RW = rw; bus.CMD_ADDR = a; bus.CMD_DATA = d;
    acc = bus.CMD_READY;
    @(posedge CLOCK); #1;
    bus.CMD_VALID = 1'b0;
    if (acc) exp_q.push_back(ref_resp(rw, a, d, hang));
  endtask

  task automatic drain(input string tag);
    int budget;
    int n;
    int k;
    resp_t g, e;
    n = exp_q.size();
    budget = 3000;
    while ((got_q.size() < n || bus.BUSY) && budget > 0) begin
      @(negedge CLOCK);
      budget--;
    end
    repeat (4) @(negedge CLOCK);
    check({tag, "_count"}, got_q.size(), n);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        check($sformatf("%s_resp%0d", tag, k), 32'(g), 32'(e));
      end
      k++;
    end
    got_q.delete();
  endtask

  task automatic clr_err();
    @(posedge CLOCK); #1 bus.CLR_ERR = 1'b1;
    @(posedge CLOCK); #1 bus.CLR_ERR = 1'b0;
    @(negedge CLOCK);
  endtask

  // Behavioural codec controller: register file behind a RDY/strobe handshake
  initial begin : ctl_model
    logic [DATA_W-1:0] mem [1 << ADDR_W];
    int ph, cnt, c_busy;
    logic c_rw;
    logic [ADDR_W-1:0] c_id;
    logic [DATA_W-1:0] c_din;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = init_val(i);
    ph = 0; cnt = 0; c_busy = 0; c_rw = 1'b0; c_id = '0; c_din = '0;
    bus.CTRL_RDY = 1'b1; bus.CTRL_DOUT = '0; bus.CTRL_DOUT_VALID = 1'b0;
    forever begin
      @(posedge CLOCK); #1;
      bus.CTRL_DOUT_VALID = 1'b0;
      if (!RESET_N) begin
        ph = 0;
        bus.CTRL_RDY = 1'b1;
      end else begin
        case (ph)
          0: begin
            bus.CTRL_RDY = !ctl_hold;
            if (bus.CTRL_WE || bus.CTRL_RE) begin
              c_rw = bus.CTRL_RE; c_id = bus.CTRL_REGID; c_din = bus.CTRL_DIN;
              if (!ctl_hang) begin
                ph = 1;
                cnt    = ctl_rand ? int'($urandom_range(4, 1)) : ack_dly;
                c_busy = ctl_rand ? int'($urandom_range(8, 0)) : busy_dly;
              end
            end
          end
          1: begin
            if (cnt <= 1) begin
              bus.CTRL_RDY = 1'b0; ph = 2; cnt = c_busy;
            end else cnt--;
          end
          2: begin
            if (cnt <= 1) begin
              if (c_rw) begin
                bus.CTRL_DOUT = mem[c_id]; bus.CTRL_DOUT_VALID = 1'b1;
              end else mem[c_id] = c_din;
              bus.CTRL_RDY = 1'b1; ph = 0;
            end else cnt--;
          end
          default: ph = 0;
        endcase
      end
    end
  end

  // Monitor: strobes and responses sampled mid-cycle
  always @(negedge CLOCK) begin
    cyc <= cyc + 1;
    if (bus.CTRL_WE) n_we <= n_we + 1;
    if (bus.CTRL_RE) n_re <= n_re + 1;
    if (bus.CTRL_WE || bus.CTRL_RE) iss_cyc <= cyc;
    if ((bus.CTRL_WE && bus.CTRL_RE) || ((bus.CTRL_WE || bus.CTRL_RE) && bus.CTRL_REGID[0]))
      n_badstb <= n_badstb + 1;
    if (bus.RESP_VALID) begin
      got_q.push_back({bus.RESP_RW, bus.RESP_ADDR, bus.RESP_DATA, bus.RESP_ERR});
      resp_cyc <= cyc;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit acc;
    int base_we, base_re;
    logic rw;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = init_val(i);
    RESET_N = 1'b0;
    bus.CMD_VALID = 1'b0; bus.CMD_RW = 1'b0; bus.CMD_ADDR = '0; bus.CMD_DATA = '0;
    bus.CLR_ERR = 1'b0;

    // Reset state
    repeat (3) @(negedge CLOCK);
    check("rst_ready", 32'(bus.CMD_READY), 1);
    check("rst_level", 32'(bus.LEVEL), 0);
    check("rst_busy", 32'(bus.BUSY), 0);
    check("rst_strobes", 32'({bus.CTRL_WE, bus.CTRL_RE, bus.RESP_VALID}), 0);
    check("rst_ctrl_bus", 32'({bus.CTRL_REGID, bus.CTRL_DIN}), 0);
    check("rst_resp", 32'({bus.RESP_RW, bus.RESP_ADDR, bus.RESP_DATA, bus.RESP_ERR}), 0);
    check("rst_sticky", 32'(bus.ERR_STICKY), 0);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLOCK);

    // Single write with delayed accept and long busy period
    ack_dly = 3; busy_dly = 20;
    base_we = n_we; base_re = n_re;
    push(1'b0, 7'h02, 16'h0000, 1'b0, acc);
    check("t1_acc", 32'(acc), 1);
    @(negedge CLOCK);
    check("t1_we_early", 32'(bus.CTRL_WE), 0);
    @(negedge CLOCK);
    check("t1_we_latency", 32'(bus.CTRL_WE), 1);
    check("t1_regid", 32'(bus.CTRL_REGID), 32'h02);
    drain("t1");
    check("t1_we_count", n_we - base_we, 1);
    check("t1_re_count", n_re - base_re, 0);
    check("t1_level", 32'(bus.LEVEL), 0);

    // Single read returning 0x0404
    ack_dly = 2; busy_dly = 3;
    base_we = n_we; base_re = n_re;
    push(1'b1, 7'h1A, 16'($urandom), 1'b0, acc);
    drain("t2");
    check("t2_re_count", n_re - base_re, 1);
    check("t2_we_count", n_we - base_we, 0);
    check("t2_data_held", 32'(bus.RESP_DATA), 32'h0404);
    check("t2_addr_held", 32'(bus.RESP_ADDR), 32'h1A);

    // Fill the FIFO while the controller is not ready
    ctl_rand = 1'b1; ctl_hold = 1'b1;
    repeat (3) @(negedge CLOCK);
    for (int i = 0; i < DEPTH + 1; i++) begin
      rw = 1'($urandom); a = 7'($urandom) & 7'h7E; d = 16'($urandom);
      push(rw, a, d, 1'b0, acc);
      check($sformatf("t3_acc%0d", i), 32'(acc), 32'(i < DEPTH));
    end
    check("t3_level_full", 32'(bus.LEVEL), DEPTH);
    check("t3_ready_low", 32'(bus.CMD_READY), 0);
    ctl_hold = 1'b0;
    drain("t3");

    // Odd address: rejected without a strobe
    ctl_rand = 1'b0; ack_dly = 1; busy_dly = 1;
    base_we = n_we; base_re = n_re;
    push(1'b0, 7'h03, 16'hBEEF, 1'b0, acc);
    drain("t4");
    check("t4_no_strobe", (n_we - base_we) + (n_re - base_re), 0);
    check("t4_resp_err", 32'(bus.RESP_ERR), 1);
    check("t4_resp_addr", 32'(bus.RESP_ADDR), 32'h03);
    check("t4_sticky", 32'(bus.ERR_STICKY), 1);
    clr_err();
    check("t4_sticky_clr", 32'(bus.ERR_STICKY), 0);

    // Controller never accepts: transaction times out
    ctl_hang = 1'b1;
    push(1'b0, 7'h10, 16'h1234, 1'b1, acc);
    drain("t5");
    check("t5_tmo_cycles", resp_cyc - iss_cyc, TIMEOUT + 1);
    check("t5_sticky", 32'(bus.ERR_STICKY), 1);
    check("t5_data_zero", 32'(bus.RESP_DATA), 0);
    ctl_hang = 1'b0;
    clr_err();
    check("t5_sticky_clr", 32'(bus.ERR_STICKY), 0);
    ack_dly = 2; busy_dly = 2;
    push(1'b0, 7'h22, 16'hA5C3, 1'b0, acc);
    push(1'b1, 7'h22, 16'h0000, 1'b0, acc);
    drain("t5_after");
    check("t5_sticky_stay", 32'(bus.ERR_STICKY), 0);

    // Randomized command stream with random controller timing
    ctl_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rw = 1'($urandom); a = 7'($urandom); d = 16'($urandom);
      if ($urandom_range(7, 0) != 0) a[0] = 1'b0;
      repeat ($urandom_range(3, 0)) @(posedge CLOCK);
      push(rw, a, d, 1'b0, acc);
    end
    drain("t6");

    // Reset during WAIT_DONE with three commands queued
    ctl_rand = 1'b0; ack_dly = 1; busy_dly = 25;
    push(1'b1, 7'h1A, 16'h0000, 1'b0, acc);
    for (int i = 0; i < 3; i++) push(1'b1, 7'(2 * i + 4), 16'h0000, 1'b0, acc);
    @(negedge CLOCK);
    check("t7_level_pre", 32'(bus.LEVEL), 3);
    check("t7_busy_pre", 32'(bus.BUSY), 1);
    @(posedge CLOCK); #3 RESET_N = 1'b0;
    #1;
    check("t7_strobes", 32'({bus.CTRL_WE, bus.CTRL_RE, bus.RESP_VALID}), 0);
    check("t7_level", 32'(bus.LEVEL), 0);
    check("t7_ready", 32'(bus.CMD_READY), 1);
    check("t7_sticky", 32'(bus.ERR_STICKY), 0);
    repeat (3) @(negedge CLOCK);
    RESET_N = 1'b1;
    exp_q.delete();
    got_q.delete();
    repeat (60) @(negedge CLOCK);
    check("t7_no_resp", got_q.size(), 0);
    check("t7_busy_post", 32'(bus.BUSY), 0);
    ack_dly = 1; busy_dly = 2;
    push(1'b0, 7'h04, 16'h7777, 1'b0, acc);
    drain("t7_after");

    check("strobe_sanity", n_badstb, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
